// File: rtl/gather_bus_pkg.sv
// Shared definitions for the result gather bus.
// Contents:
//   StateW    - width of the state encoding
//   state_e   - gather FSM state (StIdle, StDrain)
//   idx_width - lane-index width for a given lane count (clog2, minimum 1)
package gather_bus_pkg;

  localparam int unsigned StateW = 1;

  typedef enum logic [StateW-1:0] {
    StIdle  = 1'b0,
    StDrain = 1'b1
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gather_prio_enc.sv
// Lowest-set-bit priority encoder over the pending-lane mask.
// Ports:
//   pending_i - mask of lanes still waiting to be drained
//   idx_o     - index of the lowest set bit (0 when the mask is empty)
//   any_o     - at least one bit is set
//   last_o    - exactly one bit is set
// Purely combinational.
module gather_prio_enc
  import gather_bus_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 16,
  localparam int unsigned IDX_WIDTH = idx_width(ARRAY_SIZE)
) (
  input  logic [ARRAY_SIZE-1:0] pending_i,
  output logic [IDX_WIDTH-1:0]  idx_o,
  output logic                  any_o,
  output logic                  last_o
);

  // Scan from the top down so the lowest set bit is the final assignment.
  always_comb begin
    idx_o = '0;
    for (int i = int'(ARRAY_SIZE) - 1; i >= 0; i--) begin
      if (pending_i[i]) begin
        idx_o = IDX_WIDTH'(i);
      end
    end
  end

  assign any_o  = |pending_i;
  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign last_o = any_o && ((pending_i & (pending_i - ARRAY_SIZE'(1))) == '0);

endmodule

// File: rtl/result_gather_bus.sv
// Result gather bus: snapshots all valid lanes from one array edge in a single
// cycle, then serialises them onto one valid/ready stream, lowest lane first,
// tagging each beat with its source lane.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   valid_in   - per-lane valid, sampled only while in_ready is high
//   data_in    - packed lane data, lane i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   in_ready   - high when a new snapshot can be captured
//   out_valid  - output beat valid
//   out_ready  - downstream accepts the beat
//   out_data   - beat data (0 when out_valid is low)
//   out_index  - beat source lane (0 when out_valid is low)
//   out_last   - only with GATHER_BUS_LAST_EN: beat is the final one of the snapshot
// Optional feature macro: GATHER_BUS_LAST_EN.
module result_gather_bus
  import gather_bus_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = 16,
  parameter int unsigned DATA_WIDTH = 16,
  localparam int unsigned IDX_WIDTH = idx_width(ARRAY_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ARRAY_SIZE-1:0]            valid_in,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_in,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [IDX_WIDTH-1:0]             out_index
`ifdef GATHER_BUS_LAST_EN
  ,
  output logic                             out_last
`endif
);

  state_e                                state_q, state_d;
  logic [ARRAY_SIZE-1:0]                 pending_q, pending_d;
  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] bank_q, bank_d;

  logic [IDX_WIDTH-1:0] lowest_idx;
  logic                 any_set;
  logic                 last_rem;

  gather_prio_enc #(
    .ARRAY_SIZE(ARRAY_SIZE)
  ) u_prio_enc (
    .pending_i(pending_q),
    .idx_o    (lowest_idx),
    .any_o    (any_set),
    .last_o   (last_rem)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    bank_d    = bank_q;
    unique case (state_q)
      StIdle: begin
        if (|valid_in) begin
          // Invalid lanes latch zero so stale data never leaks into the bank.
          for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
            bank_d[i] = valid_in[i] ? data_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
          end
          pending_d = valid_in;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        if (out_ready && any_set) begin
          pending_d = pending_q & ~(ARRAY_SIZE'(1) << lowest_idx);
          if (last_rem) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      bank_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      bank_q    <= bank_d;
    end
  end

  // Outputs decode straight from registers, so they hold steady under stall.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDrain) && any_set;
    out_data  = out_valid ? bank_q[lowest_idx] : '0;
    out_index = out_valid ? lowest_idx : '0;
  end

`ifdef GATHER_BUS_LAST_EN
  assign out_last = out_valid && last_rem;
`endif

endmodule

// File: tb/tb_result_gather_bus.sv
module tb_result_gather_bus;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 16;

  typedef struct {
    logic [3:0]    idx;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    valid_in = '0;
  logic [N*DW-1:0] data_in = '0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic [3:0]      out_index;
`ifdef GATHER_BUS_LAST_EN
  logic            out_last;
`endif

  int passed = 0;
  int total  = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  result_gather_bus #(
    .ARRAY_SIZE(N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .data_in  (data_in),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index)
`ifdef GATHER_BUS_LAST_EN
    ,
    .out_last (out_last)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one snapshot for a single edge and record the expected beats.
  task automatic snapshot(input logic [N-1:0] v);
    check("snap_in_ready", 32'(in_ready), 32'd1);
    valid_in = v;
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) sb.push_back('{idx: 4'(i), data: data_in[i*DW +: DW]});
    end
    @(posedge clk);
    #1 valid_in = '0;
  endtask

  // Consume beats until the DUT returns to idle; every valid cycle is checked
  // against the scoreboard head, so stalled beats must hold their contents.
  task automatic drain(input bit rnd, output int beats);
    bit done = 0;
    beats = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        check("busy_in_ready", 32'(in_ready), 32'd0);
        if (sb.size() == 0) begin
          check("extra_beat", 32'(out_index), 32'hFFFF_FFFF);
          break;
        end
        check("beat_index", 32'(out_index), 32'(sb[0].idx));
        check("beat_data", 32'(out_data), 32'(sb[0].data));
`ifdef GATHER_BUS_LAST_EN
        check("beat_last", 32'(out_last), 32'(sb.size() == 1));
`endif
        if (out_ready) begin
          void'(sb.pop_front());
          beats++;
        end
      end else begin
        check("idle_gap_remaining", 32'(sb.size()), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_data", 32'(out_data), 32'd0);
        check("idle_index", 32'(out_index), 32'd0);
        done = 1;
        break;
      end
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    int beats;
    logic [N-1:0] cap;

    // Reset state.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-drain with three beats still pending.
    for (int i = 0; i < int'(N); i++) data_in[i*DW +: DW] = 16'h1000 + 16'(i);
    valid_in = 16'h000F;
    @(posedge clk);
    #1 valid_in = '0;
    @(negedge clk);
    check("pre_rst_idx0", 32'(out_index), 32'd0);
    @(negedge clk);
    check("pre_rst_idx1", 32'(out_index), 32'd1);
    check("pre_rst_data1", 32'(out_data), 32'h1001);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Single lane.
    data_in = '0;
    data_in[15:0] = 16'hABCD;
    snapshot(16'h0001);
    drain(0, beats);
    check("single_beats", 32'(beats), 32'd1);

    // Sparse snapshot, lane i = 0x0111*i, back-to-back beats.
    for (int i = 0; i < int'(N); i++) data_in[i*DW +: DW] = 16'h0111 * 16'(i);
    snapshot(16'h8421);
    drain(0, beats);
    check("sparse_beats", 32'(beats), 32'd4);

    // All lanes under random backpressure.
    for (int i = 0; i < int'(N); i++) data_in[i*DW +: DW] = 16'($urandom);
    snapshot(16'hFFFF);
    drain(1, beats);
    check("full_beats", 32'(beats), 32'd16);

    // New input while busy must wait for in_ready.
    for (int i = 0; i < int'(N); i++) data_in[i*DW +: DW] = 16'h2000 + 16'(i);
    snapshot(16'hFF00);
    valid_in = 16'h00F0;
    for (int i = 0; i < int'(N); i++) data_in[i*DW +: DW] = 16'hC000 + 16'(i);
    drain(0, beats);
    check("busy_first_beats", 32'(beats), 32'd8);
    cap = valid_in;
    for (int i = 0; i < int'(N); i++) begin
      if (cap[i]) sb.push_back('{idx: 4'(i), data: data_in[i*DW +: DW]});
    end
    @(posedge clk);
    #1 valid_in = '0;
    drain(0, beats);
    check("busy_second_beats", 32'(beats), 32'd4);

    // Last-beat flag cases (out_last is checked inside drain when enabled).
    for (int i = 0; i < int'(N); i++) data_in[i*DW +: DW] = 16'h5A00 + 16'(i);
    snapshot(16'h0042);
    drain(1, beats);
    check("two_lane_beats", 32'(beats), 32'd2);
    snapshot(16'h8000);
    drain(0, beats);
    check("top_lane_beats", 32'(beats), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
